// File: rtl/bfloat_div.sv
// bfloat16 iterative divider: one restoring-division quotient bit per cycle,
// with special operands resolved in a single cycle when they are accepted.
module bfloat_div (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] c,
   output logic        out_valid,
   input  logic        out_ready
);

   typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

   state_t             state, state_nxt;
   logic               sign;
   logic signed [9:0]  exp_r;
   logic [7:0]         divisor;
   logic [9:0]         rem;
   logic [9:0]         quo;
   logic [3:0]         cnt;

   // Operand field decode
   logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special, s_in;
   logic [15:0] special_c;
   logic signed [9:0] exp_in;
   logic       q_bit;
   logic [9:0] rem_step;

   // Normalise the 10-bit quotient, round to nearest even, then range-check.
   function automatic logic [15:0] round_pack(input logic [9:0] q, input logic rem_nz,
                                              input logic s, input logic signed [9:0] e_in);
      logic [6:0]        mant;
      logic              guard, sticky, up;
      logic [7:0]        mant_sum;
      logic signed [9:0] e;
      if (q[9]) begin
         mant   = q[8:2];
         guard  = q[1];
         sticky = q[0] | rem_nz;
         e      = e_in;
      end else begin
         mant   = q[7:1];
         guard  = q[0];
         sticky = rem_nz;
         e      = e_in - 10'sd1;
      end
      up       = guard & (sticky | mant[0]);
      mant_sum = {1'b0, mant} + {7'd0, up};
      // A carry out of the 7-bit field leaves the mantissa at zero (1.0 x 2).
      if (mant_sum[7]) begin
         mant = 7'd0;
         e    = e + 10'sd1;
      end else begin
         mant = mant_sum[6:0];
      end
      if (e >= 10'sd255)
         round_pack = {s, 8'hFF, 7'h0};
      else if (e <= 10'sd0)
         round_pack = {s, 15'h0};
      else
         round_pack = {s, e[7:0], mant};
   endfunction

   // Classify operands and build the single-cycle special-case result.
   always_comb begin
      a_zero    = (a[14:7] == 8'h00);
      b_zero    = (b[14:7] == 8'h00);
      a_inf     = (a[14:7] == 8'hFF) && (a[6:0] == 7'h0);
      b_inf     = (b[14:7] == 8'hFF) && (b[6:0] == 7'h0);
      a_nan     = (a[14:7] == 8'hFF) && (a[6:0] != 7'h0);
      b_nan     = (b[14:7] == 8'hFF) && (b[6:0] != 7'h0);
      s_in      = a[15] ^ b[15];
      special   = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
      exp_in    = $signed({2'b00, a[14:7]}) - $signed({2'b00, b[14:7]}) + 10'sd127;
      special_c = {s_in, 15'h0};
      if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf))
         special_c = 16'hFFFF;
      else if (b_zero | a_inf)
         special_c = {s_in, 8'hFF, 7'h0};
   end

   // One restoring-division step: subtract when the partial remainder allows.
   always_comb begin
      q_bit    = (rem >= {2'b00, divisor});
      rem_step = q_bit ? ((rem - {2'b00, divisor}) << 1) : (rem << 1);
   end

   // Next-state logic and handshake outputs
   always_comb begin
      state_nxt = state;
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      case (state)
         IDLE:    if (in_valid) state_nxt = special ? DONE : DIVIDE;
         DIVIDE:  if (cnt == 4'd9) state_nxt = ROUND;
         ROUND:   state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Datapath registers: operand load, iteration, and result write
   always_ff @(posedge clk) begin
      if (rst) begin
         c       <= 16'h0000;
         sign    <= 1'b0;
         exp_r   <= 10'sd0;
         divisor <= 8'd0;
         rem     <= 10'd0;
         quo     <= 10'd0;
         cnt     <= 4'd0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               if (special) begin
                  c <= special_c;
               end else begin
                  sign    <= s_in;
                  exp_r   <= exp_in;
                  divisor <= {1'b1, b[6:0]};
                  rem     <= {3'b001, a[6:0]};
                  quo     <= 10'd0;
                  cnt     <= 4'd0;
               end
            end
            DIVIDE: begin
               rem <= rem_step;
               quo <= {quo[8:0], q_bit};
               cnt <= cnt + 4'd1;
            end
            ROUND:   c <= round_pack(quo, rem != 10'd0, sign, exp_r);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bfloat_div.sv
// Scoreboard bench for bfloat_div: directed vectors, a stalled consumer,
// a mid-divide reset, and a batch of random operand pairs.
module tb_bfloat_div;

   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready, in_ready, out_valid;
   logic [15:0] a, b, c;

   always #5 clk = ~clk;

   bfloat_div dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
      .c(c), .out_valid(out_valid), .out_ready(out_ready)
   );

   int          errors = 0;
   int          checks = 0;
   logic [15:0] exp_q[$];
   int          lat_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference: exact integer quotient with wide precision, then RNE.
   function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y, output int lat);
      logic        s;
      int          ex, ey, e;
      int unsigned mx, my, num, q, r, mant, dropped, half, sh;
      logic        xz, yz, xi, yi, xn, yn, up;
      s  = x[15] ^ y[15];
      ex = int'(x[14:7]);
      ey = int'(y[14:7]);
      xz = (ex == 0);   yz = (ey == 0);
      xi = (ex == 255) && (x[6:0] == 0);  yi = (ey == 255) && (y[6:0] == 0);
      xn = (ex == 255) && (x[6:0] != 0);  yn = (ey == 255) && (y[6:0] != 0);
      lat = 1;
      if (xn || yn || (xz && yz) || (xi && yi)) return 16'hFFFF;
      if (yz || xi) return {s, 8'hFF, 7'h0};
      if (xz || yi) return {s, 15'h0};
      lat = 12;
      mx  = 128 + int'(x[6:0]);
      my  = 128 + int'(y[6:0]);
      num = mx << 20;
      q   = num / my;
      r   = num % my;
      e   = ex - ey + 127;
      if (q >= (1 << 20)) sh = 13;
      else begin sh = 12; e = e - 1; end
      mant    = q >> sh;
      dropped = q & ((1 << sh) - 1);
      half    = 1 << (sh - 1);
      up      = (dropped > half) || ((dropped == half) && ((r != 0) || mant[0]));
      if (up) mant = mant + 1;
      if (mant == 256) begin mant = 128; e = e + 1; end
      if (e >= 255) return {s, 8'hFF, 7'h0};
      if (e <= 0) return {s, 15'h0};
      return {s, e[7:0], mant[6:0]};
   endfunction

   // Issue one operation, measure latency, stall the consumer for 'hold' cycles.
   task automatic run_op(input logic [15:0] x, input logic [15:0] y, input int hold);
      int          lat, n;
      logic [15:0] e, held;
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      check("in_ready_wait", in_ready, 1);
      e = model(x, y, lat);
      exp_q.push_back(e);
      lat_q.push_back(lat);
      a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
      // Keep in_valid high with junk data: nothing may be accepted until IDLE.
      a = 16'($urandom); b = 16'($urandom);
      n = 1;
      while (!out_valid && n < 30) begin @(posedge clk); #1; n++; end
      check("latency", n, lat_q.pop_front());
      held = c;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_c", c, held);
         check("hold_in_ready", in_ready, 0);
         check("hold_out_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check($sformatf("result %h/%h", x, y), held, exp_q.pop_front());
      check("valid_clr", out_valid, 0);
      check("c_retain", c, held);
      check("no_accept_on_consume", in_ready, 1);
      in_valid = 1'b0;
   endtask

   initial begin
      logic [15:0] x, y;
      int          sel;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 16'h0; b = 16'h0;
      @(posedge clk); @(posedge clk); #1;
      check("rst_c", c, 16'h0000);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      rst = 1'b0;

      run_op(16'h3F80, 16'h3F80, 0);
      run_op(16'h3F80, 16'h4040, 1);
      run_op(16'hC080, 16'h4000, 0);
      run_op(16'h40A0, 16'h0000, 0);
      run_op(16'h0000, 16'h0000, 0);
      run_op(16'h7F80, 16'h3F80, 0);
      run_op(16'h40C0, 16'h4000, 5);
      run_op(16'h7F00, 16'h0080, 0);
      run_op(16'h0080, 16'h7F00, 0);
      run_op(16'h7FC1, 16'h3F80, 0);
      run_op(16'h7F80, 16'hFF80, 0);
      run_op(16'hBF80, 16'h7F80, 0);
      run_op(16'h0045, 16'h4000, 0);
      run_op(16'h3FFF, 16'h3F81, 0);

      // Abort an operation part-way through DIVIDE.
      a = 16'h3F80; b = 16'h3F80; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_c", c, 16'h0000);
      check("abort_out_valid", out_valid, 0);
      check("abort_in_ready", in_ready, 1);
      repeat (12) @(posedge clk);
      #1;
      check("abort_no_result", out_valid, 0);
      run_op(16'h3F80, 16'h3F80, 0);

      for (int i = 0; i < 30; i++) begin
         x = 16'($urandom);
         y = 16'($urandom);
         sel = $urandom_range(0, 9);
         if (sel < 7) begin
            x[14:7] = 8'($urandom_range(60, 190));
            y[14:7] = 8'($urandom_range(60, 190));
         end
         run_op(x, y, $urandom_range(0, 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bfloat_div.md
BFLOAT_DIV -- requirements
Module: bfloat_div

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 a  input  16  bfloat16 dividend (sign[15], exp[14:7], mant[6:0]).
REQ-005 b  input  16  bfloat16 divisor, same format.
REQ-006 in_valid  input  1  a/b valid this cycle.
REQ-007 in_ready  output  1  block can accept an operand pair.
REQ-008 c  output  16  bfloat16 quotient, registered.
REQ-009 out_valid  output  1  c holds a completed result.
REQ-010 out_ready  input  1  consumer accepts c.

Function
REQ-011 The block SHALL be a multi-cycle iterative divider, the counterpart of the team's bfloat_add_sub/multiply datapath, with exactly one operation in flight.
REQ-012 The block SHALL use states IDLE, DIVIDE, ROUND, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-013 Operands SHALL be accepted on an edge with in_valid & in_ready; a/b are ignored at all other times.
REQ-014 Special cases SHALL be resolved at acceptance, writing c and moving IDLE->DONE on the same edge (latency 1):
  - either operand NaN (exp=FF, mant!=0), 0/0, or inf/inf -> c=16'hFFFF (team NaN encoding);
  - finite nonzero or inf / zero, and inf / finite -> signed infinity {s,8'hFF,7'h0};
  - zero / nonzero, finite / inf -> signed zero {s,15'h0};
  - s = a[15]^b[15] for all non-NaN results.
REQ-015 Operands with exp=0 SHALL be treated as zero (denormal flush).
REQ-016 Normal operands SHALL load significands {1,mant} (8 bits), sign s, and a 10-bit signed exponent ea-eb+127, then move IDLE->DIVIDE with a 4-bit counter cleared.
REQ-017 DIVIDE SHALL perform one restoring-division step per cycle, producing one quotient bit MSB-first, for exactly 10 cycles (q[9:0], q[9] = integer bit), then move to ROUND.
REQ-018 ROUND SHALL normalize: if q[9]=1, mantissa=q[8:2], guard=q[1], sticky=q[0] | (remainder!=0); else mantissa=q[7:1], guard=q[0], sticky=(remainder!=0), exponent-1.
REQ-019 Rounding SHALL be round-to-nearest-even: increment the mantissa when guard & (sticky | mantissa[0]); a carry out of the mantissa SHALL clear it to 0 and increment the exponent.
REQ-020 After rounding, exponent >= 255 SHALL give signed infinity and exponent <= 0 SHALL give signed zero; otherwise c={s,exp[7:0],mant}.
REQ-021 ROUND SHALL write c and move to DONE; latency of a normal operation SHALL be 12 edges from the accepting edge to out_valid asserted (1 load + 10 divide + 1 round).
REQ-022 In DONE, c and out_valid SHALL hold stable until out_ready=1; on that edge state returns to IDLE and out_valid deasserts; c retains its last value.
REQ-023 A new operand pair SHALL NOT be accepted on the same edge a result is consumed (in_ready low in DONE).

Reset
REQ-024 On rst=1 at a rising edge, state SHALL become IDLE, c=16'h0000, out_valid=0, in_ready=1, counter/remainder/quotient cleared.
REQ-025 rst SHALL take priority over all handshakes and abort any operation in DIVIDE or ROUND with no result produced.

Verification
REQ-026 a=3F80 (1.0), b=3F80 -> c=3F80, out_valid 12 edges after acceptance.
REQ-027 a=3F80, b=4040 (3.0) -> c=3EAB (round-up path); a=C080 (-4.0), b=4000 -> c=C000.
REQ-028 a=40A0 (5.0), b=0000 -> c=7F80 after 1 edge; a=0000, b=0000 -> c=FFFF; a=7F80, b=3F80 -> c=7F80.
REQ-029 a=40C0 (6.0), b=4000, out_ready held 0 for 5 cycles after out_valid -> c=4040 stable, in_ready=0 throughout, cleared on the out_ready edge.
REQ-030 rst asserted at DIVIDE cycle 5 -> next edge state IDLE, c=0000, out_valid=0; a following 3F80/3F80 completes normally with c=3F80.
REQ-031 a=7F00, b=0080 (overflow) -> c=7F80; a=0080, b=7F00 (underflow) -> c=0000.
